riscv_writeback: RTL and testbench
==================================

# riscv_writeback

Write-back queue between the execute/memory stages and the `RiscVRegs` write port. It accepts results from the ALU and the load unit over valid/ready handshakes, buffers them in order, and drains one per cycle into `enable_write_rd`/`rd_index`/`rd`. It also reports to the decoder which source registers still have writes in flight.

## Interface
- `FIFO_DEPTH`, default 4: queue entries; power of 2, minimum 2.
- `REG_COUNT`, default 32: architectural registers; index width is 5.

Ports:
- `clock` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `mem_valid` in 1, `mem_rd_index` in 5, `mem_rd` in 32: load result.
- `mem_ready` out 1: a load result can be accepted.
- `alu_valid` in 1, `alu_rd_index` in 5, `alu_rd` in 32: ALU result.
- `alu_ready` out 1: an ALU result can be accepted.
- `enable_write_rd` out 1, `rd_index` out 5, `rd` out 32: register-file write port.
- `rs1_index` in 5, `rs2_index` in 5: decoder source indices.
- `rs1_busy` out 1, `rs2_busy` out 1: a pending write targets that source.
- `rs1_fwd` out 1, `rs1_fwd_data` out 32, `rs2_fwd` out 1, `rs2_fwd_data` out 32: forwarding outputs.

## Operation
- **Queue:** circular FIFO with head/tail pointers and a count (0..FIFO_DEPTH). Each entry holds index and data.
- **Ready:**
  - `mem_ready` = free ≥ 1.
  - `alu_ready` = free ≥ 2.
  - Both depend only on registered count, never on valid.
- **Accept:** a source is accepted when valid and ready are both high.
  - Both sources may be accepted in the same cycle. The mem entry goes in first (older), then the ALU entry.
  - Results with index 0 are accepted but not enqueued.
- **Drain:** when count > 0, the head is popped every cycle into the output stage.
  - Output-stage registers: `enable_write_rd`, `rd_index`, `rd`.
  - When empty, `enable_write_rd` = 0 and `rd_index`/`rd` hold their values.
- **Simultaneous events:** pop and up to two pushes in the same cycle. New count = count − pop + pushes, never above FIFO_DEPTH by construction of ready.
- **Pointer wrap:** pointers wrap modulo FIFO_DEPTH with no bubble.
- **Pending set:** all valid FIFO entries, plus the output stage while `enable_write_rd` = 1. Index 0 never matches.
- **Reset mid-operation:** all queued entries and the output stage are discarded immediately. Nothing is written after reset deasserts.

## Timing
- **Reset values:**
  - `enable_write_rd` = 0, `rd_index` = 0, `rd` = 0.
  - `mem_ready` = 1, `alu_ready` = 1.
  - All busy/fwd outputs = 0, `rs*_fwd_data` = 0.
- **Latency:** a result accepted at edge N (empty queue) is at the head after N, appears on the write port after N+1, and is written into the register file at N+2.
- **Throughput:** one register write per cycle.
- **Busy/fwd outputs:** purely combinational from the pending set and `rs*_index`. They reflect state after the last edge, not this cycle's accepts.
- **Ready after accept:** ready deasserts the cycle after the accept that fills the queue.

## Configuration
- **Macro `RISCV_WB_FORWARD_EN`:**
  - **Defined:**
    - `rsN_fwd` = 1 when the pending set matches `rsN_index`.
    - `rsN_fwd_data` = the newest match; priority is youngest FIFO entry, then older entries, then the output stage.
    - `rsN_busy` is tied to 0.
  - **Undefined:**
    - `rsN_busy` = match.
    - `rsN_fwd` and `rsN_fwd_data` are tied to 0, and the compare/mux logic is absent.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream with 3 queued entries, then release → no write strobe afterward, count 0, both readies = 1.
- **Single write:** `alu_valid` with index 5, data 0x1234 at edge N → `enable_write_rd` = 1, `rd_index` = 5, `rd` = 0x1234 during cycle N+1..N+2 only.
- **Dual accept, same index:** mem (x3 = 0xA) and ALU (x3 = 0xB) in the same cycle → writes x3 = 0xA then x3 = 0xB on consecutive cycles. With forwarding, `rs1_index` = 3 gives `rs1_fwd_data` = 0xB until drained.
- **Full queue:** hold both valids with DEPTH = 4 → `alu_ready` drops at count ≥ 3 and `mem_ready` at count 4. No entry is lost or reordered, and the pointers wrap.
- **x0 results:** mem index 0 and ALU index 0 → both accepted, no write strobe, `rs1_busy`/`rs1_fwd` = 0 for `rs1_index` = 0.
- **Busy (no forwarding):** pending write to x7 → `rs2_busy` = 1 with `rs2_index` = 7 until the cycle after the x7 strobe, then 0.

Source files
------------

// File: rtl/riscv_writeback.sv
// Write-back queue: buffers ALU and load results in order and drains one per cycle to the
// register-file write port. Optional forwarding is enabled with RISCV_WB_FORWARD_EN.
module riscv_writeback #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mem_valid,
  input  logic [$clog2(REG_COUNT)-1:0] mem_rd_index,
  input  logic [31:0]                  mem_rd,
  output logic                         mem_ready,
  input  logic                         alu_valid,
  input  logic [$clog2(REG_COUNT)-1:0] alu_rd_index,
  input  logic [31:0]                  alu_rd,
  output logic                         alu_ready,
  output logic                         enable_write_rd,
  output logic [$clog2(REG_COUNT)-1:0] rd_index,
  output logic [31:0]                  rd,
  input  logic [$clog2(REG_COUNT)-1:0] rs1_index,
  input  logic [$clog2(REG_COUNT)-1:0] rs2_index,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic                         rs1_fwd,
  output logic [31:0]                  rs1_fwd_data,
  output logic                         rs2_fwd,
  output logic [31:0]                  rs2_fwd_data
);

  localparam int unsigned IdxW = $clog2(REG_COUNT);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [IdxW-1:0] idx_q  [FIFO_DEPTH];
  logic [IdxW-1:0] idx_d  [FIFO_DEPTH];
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     data_d [FIFO_DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_en_q, wr_en_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic            mem_push, alu_push, pop;

  // Readiness looks only at the registered count so it never depends on this cycle's valids.
  assign mem_ready = count_q < CntW'(FIFO_DEPTH);
  assign alu_ready = count_q <= CntW'(FIFO_DEPTH - 2);

  assign mem_push = mem_valid & mem_ready & (mem_rd_index != '0);
  assign alu_push = alu_valid & alu_ready & (alu_rd_index != '0);
  assign pop      = count_q != '0;

  always_comb begin
    idx_d     = idx_q;
    data_d    = data_q;
    head_d    = head_q;
    wr_en_d   = pop;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_idx_d  = idx_q[head_q];
      wr_data_d = data_q[head_q];
      head_d    = head_q + PtrW'(1);
    end
    // The load result is older, so it takes the first free slot.
    alu_slot = tail_q + PtrW'(mem_push);
    if (mem_push) begin
      idx_d[tail_q]  = mem_rd_index;
      data_d[tail_q] = mem_rd;
    end
    if (alu_push) begin
      idx_d[alu_slot]  = alu_rd_index;
      data_d[alu_slot] = alu_rd;
    end
    tail_d  = tail_q + PtrW'(mem_push) + PtrW'(alu_push);
    count_d = count_q - CntW'(pop) + CntW'(mem_push) + CntW'(alu_push);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        idx_q[i]  <= '0;
        data_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      idx_q     <= idx_d;
      data_q    <= data_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign enable_write_rd = wr_en_q;
  assign rd_index        = wr_idx_q;
  assign rd              = wr_data_q;

  logic [IdxW-1:0] rs_idx [2];
  logic            rs_hit [2];
  logic [PtrW-1:0] slot;

  assign rs_idx[0] = rs1_index;
  assign rs_idx[1] = rs2_index;

`ifdef RISCV_WB_FORWARD_EN
  logic [31:0] rs_data [2];

  // Walk oldest to youngest so the youngest matching entry wins; output stage is oldest.
  always_comb begin
    slot = head_q;
    for (int r = 0; r < 2; r++) begin
      rs_hit[r]  = wr_en_q && (wr_idx_q == rs_idx[r]);
      rs_data[r] = rs_hit[r] ? wr_data_q : '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        slot = head_q + PtrW'(k);
        if ((CntW'(k) < count_q) && (idx_q[slot] == rs_idx[r])) begin
          rs_hit[r]  = 1'b1;
          rs_data[r] = data_q[slot];
        end
      end
      if (rs_idx[r] == '0) begin
        rs_hit[r]  = 1'b0;
        rs_data[r] = '0;
      end
    end
  end

  assign rs1_busy     = 1'b0;
  assign rs2_busy     = 1'b0;
  assign rs1_fwd      = rs_hit[0];
  assign rs2_fwd      = rs_hit[1];
  assign rs1_fwd_data = rs_data[0];
  assign rs2_fwd_data = rs_data[1];
`else
  always_comb begin
    slot = head_q;
    for (int r = 0; r < 2; r++) begin
      rs_hit[r] = wr_en_q && (wr_idx_q == rs_idx[r]);
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        slot = head_q + PtrW'(k);
        if ((CntW'(k) < count_q) && (idx_q[slot] == rs_idx[r])) rs_hit[r] = 1'b1;
      end
      if (rs_idx[r] == '0) rs_hit[r] = 1'b0;
    end
  end

  assign rs1_busy     = rs_hit[0];
  assign rs2_busy     = rs_hit[1];
  assign rs1_fwd      = 1'b0;
  assign rs2_fwd      = 1'b0;
  assign rs1_fwd_data = '0;
  assign rs2_fwd_data = '0;
`endif

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed bench for riscv_writeback: hand-checked scenarios plus an in-order write scoreboard.
module tb_riscv_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid, mem_ready, alu_ready;
  logic [4:0]  mem_rd_index, alu_rd_index, rd_index, rs1_index, rs2_index;
  logic [31:0] mem_rd, alu_rd, rd, rs1_fwd_data, rs2_fwd_data;
  logic        enable_write_rd, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] sb [$];
  logic        m_we;
  logic [4:0]  m_idx;
  logic [31:0] m_data;

  riscv_writeback dut (
    .clock          (clock),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_rd_index   (mem_rd_index),
    .mem_rd         (mem_rd),
    .mem_ready      (mem_ready),
    .alu_valid      (alu_valid),
    .alu_rd_index   (alu_rd_index),
    .alu_rd         (alu_rd),
    .alu_ready      (alu_ready),
    .enable_write_rd(enable_write_rd),
    .rd_index       (rd_index),
    .rd             (rd),
    .rs1_index      (rs1_index),
    .rs2_index      (rs2_index),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .rs1_fwd        (rs1_fwd),
    .rs1_fwd_data   (rs1_fwd_data),
    .rs2_fwd        (rs2_fwd),
    .rs2_fwd_data   (rs2_fwd_data)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pending-write check for one source port; busy or fwd depending on the build.
  task automatic check_rs(input string tag, input bit second, input logic hit,
                          input logic [31:0] data);
`ifdef RISCV_WB_FORWARD_EN
    check_eq({tag, "_fwd"}, second ? rs2_fwd : rs1_fwd, {31'b0, hit});
    check_eq({tag, "_data"}, second ? rs2_fwd_data : rs1_fwd_data, data);
    check_eq({tag, "_busy"}, second ? rs2_busy : rs1_busy, 32'd0);
`else
    check_eq({tag, "_busy"}, second ? rs2_busy : rs1_busy, {31'b0, hit});
    check_eq({tag, "_fwd"}, second ? rs2_fwd : rs1_fwd, 32'd0);
`endif
  endtask

  // One clock: predicts readies and the write port from the scoreboard, then compares.
  task automatic tick();
    logic        mr, ar;
    logic [36:0] e;
    mr = sb.size() < 4;
    ar = sb.size() <= 2;
    check_eq("mem_ready", {31'b0, mem_ready}, {31'b0, mr});
    check_eq("alu_ready", {31'b0, alu_ready}, {31'b0, ar});
    m_we = 1'b0;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      m_we   = 1'b1;
      m_idx  = e[36:32];
      m_data = e[31:0];
    end
    if (mem_valid && mr && mem_rd_index != 5'd0) sb.push_back({mem_rd_index, mem_rd});
    if (alu_valid && ar && alu_rd_index != 5'd0) sb.push_back({alu_rd_index, alu_rd});
    @(posedge clock);
    #1;
    check_eq("wr_en", {31'b0, enable_write_rd}, {31'b0, m_we});
    check_eq("wr_idx", {27'b0, rd_index}, {27'b0, m_idx});
    check_eq("wr_data", rd, m_data);
  endtask

  initial begin
    reset = 1'b0;
    mem_valid = 1'b0; mem_rd_index = '0; mem_rd = '0;
    alu_valid = 1'b0; alu_rd_index = '0; alu_rd = '0;
    rs1_index = '0; rs2_index = '0;
    m_we = 1'b0; m_idx = '0; m_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_en", {31'b0, enable_write_rd}, 32'd0);
    check_eq("rst_idx", {27'b0, rd_index}, 32'd0);
    check_eq("rst_rd", rd, 32'd0);
    check_eq("rst_mem_ready", {31'b0, mem_ready}, 32'd1);
    check_eq("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    check_eq("rst_busy", {30'b0, rs1_busy, rs2_busy}, 32'd0);
    check_eq("rst_fwd", {30'b0, rs1_fwd, rs2_fwd}, 32'd0);
    check_eq("rst_fwd_data", rs1_fwd_data | rs2_fwd_data, 32'd0);
    reset = 1'b1;

    // Single ALU write to x5.
    rs1_index = 5'd5;
    alu_valid = 1'b1; alu_rd_index = 5'd5; alu_rd = 32'h1234;
    tick();
    alu_valid = 1'b0;
    check_eq("single_n_en", {31'b0, enable_write_rd}, 32'd0);
    check_rs("single_n_pend", 1'b0, 1'b1, 32'h1234);
    tick();
    check_eq("single_n1_en", {31'b0, enable_write_rd}, 32'd1);
    check_eq("single_n1_idx", {27'b0, rd_index}, 32'd5);
    check_eq("single_n1_rd", rd, 32'h1234);
    check_rs("single_n1_pend", 1'b0, 1'b1, 32'h1234);
    tick();
    check_eq("single_n2_en", {31'b0, enable_write_rd}, 32'd0);
    check_eq("single_n2_hold", {27'b0, rd_index}, 32'd5);
    check_rs("single_n2_pend", 1'b0, 1'b0, 32'd0);

    // Dual accept to x3: mem 0xA is older than ALU 0xB.
    rs1_index = 5'd3;
    mem_valid = 1'b1; mem_rd_index = 5'd3; mem_rd = 32'hA;
    alu_valid = 1'b1; alu_rd_index = 5'd3; alu_rd = 32'hB;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    check_rs("dual_q", 1'b0, 1'b1, 32'hB);
    tick();
    check_eq("dual_first", rd, 32'hA);
    check_rs("dual_w1", 1'b0, 1'b1, 32'hB);
    tick();
    check_eq("dual_second", rd, 32'hB);
    check_eq("dual_second_en", {31'b0, enable_write_rd}, 32'd1);
    check_rs("dual_w2", 1'b0, 1'b1, 32'hB);
    tick();
    check_rs("dual_done", 1'b0, 1'b0, 32'd0);

    // Both valids held: queue settles at 3 entries, pointers wrap repeatedly.
    mem_valid = 1'b1; alu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_rd_index = 5'(i % 31 + 1);       mem_rd = 32'h100 + 32'(i);
      alu_rd_index = 5'((i + 7) % 31 + 1); alu_rd = 32'h200 + 32'(i);
      tick();
    end
    check_eq("full_alu_ready", {31'b0, alu_ready}, 32'd0);
    check_eq("full_mem_ready", {31'b0, mem_ready}, 32'd1);
    mem_valid = 1'b0; alu_valid = 1'b0;
    repeat (5) tick();
    check_eq("full_drained_en", {31'b0, enable_write_rd}, 32'd0);

    // x0 results are accepted but never written.
    rs1_index = 5'd0;
    mem_valid = 1'b1; mem_rd_index = 5'd0; mem_rd = 32'h55;
    alu_valid = 1'b1; alu_rd_index = 5'd0; alu_rd = 32'h66;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    check_rs("x0_pend", 1'b0, 1'b0, 32'd0);
    tick();
    check_eq("x0_no_write", {31'b0, enable_write_rd}, 32'd0);
    tick();

    // Pending write to x7 seen on rs2 until the cycle after its strobe.
    rs2_index = 5'd7;
    alu_valid = 1'b1; alu_rd_index = 5'd7; alu_rd = 32'h77;
    tick();
    alu_valid = 1'b0;
    check_rs("busy_q", 1'b1, 1'b1, 32'h77);
    tick();
    check_eq("busy_strobe_idx", {27'b0, rd_index}, 32'd7);
    check_rs("busy_strobe", 1'b1, 1'b1, 32'h77);
    tick();
    check_rs("busy_clear", 1'b1, 1'b0, 32'd0);

    // Reset with three queued entries and a live output stage.
    mem_valid = 1'b1; mem_rd_index = 5'd9;  mem_rd = 32'h90;
    alu_valid = 1'b1; alu_rd_index = 5'd10; alu_rd = 32'hA0;
    tick();
    mem_rd_index = 5'd11; mem_rd = 32'hB0;
    alu_rd_index = 5'd12; alu_rd = 32'hC0;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("mrst_en", {31'b0, enable_write_rd}, 32'd0);
    check_eq("mrst_idx", {27'b0, rd_index}, 32'd0);
    check_eq("mrst_ready", {30'b0, mem_ready, alu_ready}, 32'd3);
    sb.delete();
    m_we = 1'b0; m_idx = '0; m_data = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
